// File: rtl/mux_rr_stream.sv
// Round-robin N_CH:1 valid/ready stream mux with a registered output.
// Define MUX_FORCE_SEL_EN to add the force_en/force_sel manual-select ports.
module mux_rr_stream #(
   parameter int N_CH = 4,
   parameter int W = 2,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
`ifdef MUX_FORCE_SEL_EN
   input  logic              force_en,
   input  logic [SEL_W-1:0]  force_sel,
`endif
   input  logic              out_ready
);

   logic [SEL_W-1:0] last_gnt;
   logic [SEL_W-1:0] gnt;
   logic             found;
   logic             load_en;
   logic [N_CH-1:0]  elig;
   logic [W-1:0]     sel_data;

`ifdef MUX_FORCE_SEL_EN
   logic [N_CH-1:0] force_mask;

   // Out-of-range force_sel matches no channel, so nothing is eligible.
   always_comb begin
      force_mask = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (int'(force_sel) == i) force_mask[i] = 1'b1;
      end
   end

   assign elig = force_en ? (in_valid & force_mask) : in_valid;
`else
   assign elig = in_valid;
`endif

   assign load_en = !out_valid | out_ready;

   // Search starts just after the last granted channel and wraps at N_CH-1.
   always_comb begin
      logic [SEL_W-1:0] cand;
      found = 1'b0;
      gnt   = '0;
      cand  = '0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = SEL_W'((int'(last_gnt) + k) % N_CH);
         if (!found && elig[cand]) begin
            found = 1'b1;
            gnt   = cand;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (SEL_W'(i) == gnt) sel_data = in_data[i*W +: W];
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && found) in_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         last_gnt  <= SEL_W'(N_CH - 1);
      end else if (load_en) begin
         if (found) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt;
            last_gnt  <= gnt;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Randomized bench for mux_rr_stream: a 4-channel and a 3-channel instance
// checked each cycle against a queue-free behavioural arbiter model.
module tb_mux_rr_stream;

   localparam int W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] v[2];
   logic [31:0] d[2];
   logic        ordy[2];
   logic        fe[2];
   logic [1:0]  fs[2];

   logic [3:0]   rdy_a;
   logic [2:0]   rdy_b;
   logic [W-1:0] od_a, od_b;
   logic [1:0]   oc_a, oc_b;
   logic         ov_a, ov_b;

   int cmp_cnt = 0;
   int err_cnt = 0;

   int m_ov[2], m_od[2], m_oc[2], m_last[2];

   mux_rr_stream #(.N_CH(4), .W(W)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(d[0][7:0]), .in_valid(v[0][3:0]), .in_ready(rdy_a),
      .out_data(od_a), .out_ch(oc_a), .out_valid(ov_a),
`ifdef MUX_FORCE_SEL_EN
      .force_en(fe[0]), .force_sel(fs[0]),
`endif
      .out_ready(ordy[0])
   );

   mux_rr_stream #(.N_CH(3), .W(W)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(d[1][5:0]), .in_valid(v[1][2:0]), .in_ready(rdy_b),
      .out_data(od_b), .out_ch(oc_b), .out_valid(ov_b),
`ifdef MUX_FORCE_SEL_EN
      .force_en(fe[1]), .force_sel(fs[1]),
`endif
      .out_ready(ordy[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nch(input int u);
      return (u == 0) ? 4 : 3;
   endfunction

   // First valid (and, if forced, selected) channel after the last grant.
   function automatic int pick(input int u);
      int n, c;
      n = nch(u);
      for (int k = 1; k <= n; k++) begin
         c = (m_last[u] + k) % n;
         if (v[u][c] && (!fe[u] || int'(fs[u]) == c)) return c;
      end
      return -1;
   endfunction

   function automatic logic [31:0] get_rdy(input int u);
      return (u == 0) ? 32'(rdy_a) : 32'(rdy_b);
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_ov[u] = 0; m_od[u] = 0; m_oc[u] = 0; m_last[u] = nch(u) - 1;
      end
   endtask

   task automatic cycle();
      int g;
      bit can_load;
      logic [31:0] er;
      #2;
      for (int u = 0; u < 2; u++) begin
         g = pick(u);
         can_load = (m_ov[u] == 0) || ordy[u];
         er = (rst_n && can_load && g >= 0) ? (32'd1 << g) : 32'd0;
         chk(u == 0 ? "ready_a" : "ready_b", get_rdy(u), er);
      end
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
         g = pick(u);
         can_load = (m_ov[u] == 0) || ordy[u];
         if (!rst_n) begin
            m_ov[u] = 0; m_od[u] = 0; m_oc[u] = 0; m_last[u] = nch(u) - 1;
         end else if (can_load) begin
            if (g >= 0) begin
               m_ov[u] = 1; m_oc[u] = g; m_last[u] = g;
               m_od[u] = int'((d[u] >> (g * W)) & ((32'd1 << W) - 1));
            end else begin
               m_ov[u] = 0;
            end
         end
      end
      #1;
      chk("valid_a", 32'(ov_a), 32'(m_ov[0]));
      chk("ch_a", 32'(oc_a), 32'(m_oc[0]));
      chk("data_a", 32'(od_a), 32'(m_od[0]));
      chk("valid_b", 32'(ov_b), 32'(m_ov[1]));
      chk("ch_b", 32'(oc_b), 32'(m_oc[1]));
      chk("data_b", 32'(od_b), 32'(m_od[1]));
   endtask

   task automatic set_all(input logic [15:0] va, input logic [15:0] vb,
                          input logic r);
      v[0] = va; v[1] = vb; ordy[0] = r; ordy[1] = r;
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      d[0] = 32'h0000_00e4;
      d[1] = 32'h0000_0024;
      fe[0] = 1'b0; fe[1] = 1'b0; fs[0] = 2'd0; fs[1] = 2'd0;
      set_all(16'hf, 16'h7, 1'b1);

      // Reset held with everything valid.
      repeat (2) cycle();
      chk("rst_ready_a", 32'(rdy_a), 32'd0);
      chk("rst_valid_a", 32'(ov_a), 32'd0);
      chk("rst_ch_a", 32'(oc_a), 32'd0);
      chk("rst_data_a", 32'(od_a), 32'd0);

      // Round-robin with data equal to channel id.
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("rr_seq_a", 32'(oc_a), 32'(i % 4));
         chk("rr_data_a", 32'(od_a), 32'(i % 4));
         chk("rr_seq_b", 32'(oc_b), 32'(i % 3));
         chk("rr_nobubble_a", 32'(ov_a), 32'd1);
      end

      // Backpressure holding ch2 on the 4-channel instance.
      ordy[0] = 1'b0; ordy[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_ch_a", 32'(oc_a), 32'd2);
         chk("bp_data_a", 32'(od_a), 32'd2);
         chk("bp_ready_a", 32'(rdy_a), 32'd0);
      end
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      cycle();
      chk("bp_next_a", 32'(oc_a), 32'd3);

      // Sparse and wrap, then drain.
      set_all(16'h2, 16'h2, 1'b1);
      cycle();
      chk("sparse1_a", 32'(oc_a), 32'd1);
      set_all(16'h1, 16'h1, 1'b1);
      cycle();
      chk("sparse0_a", 32'(oc_a), 32'd0);
      set_all(16'h0, 16'h0, 1'b1);
      cycle();
      chk("drain_a", 32'(ov_a), 32'd0);
      chk("drain_b", 32'(ov_b), 32'd0);

`ifdef MUX_FORCE_SEL_EN
      set_all(16'hf, 16'h7, 1'b1);
      fe[0] = 1'b1; fs[0] = 2'd2;
      fe[1] = 1'b1; fs[1] = 2'd3;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("force_ch_a", 32'(oc_a), 32'd2);
      end
      chk("force_oob_b", 32'(ov_b), 32'd0);
      fe[0] = 1'b0; fe[1] = 1'b0;
      cycle();
      chk("force_resume_a", 32'(oc_a), 32'd3);
`endif

      // Random traffic with occasional mid-run resets.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         v[0] = 16'($urandom) & 16'hf;
         v[1] = 16'($urandom) & 16'h7;
         d[0] = $urandom;
         d[1] = $urandom;
         ordy[0] = ($urandom_range(0, 3) != 0);
         ordy[1] = ($urandom_range(0, 3) != 0);
`ifdef MUX_FORCE_SEL_EN
         fe[0] = ($urandom_range(0, 3) == 0);
         fe[1] = ($urandom_range(0, 3) == 0);
         fs[0] = 2'($urandom);
         fs[1] = 2'($urandom);
`endif
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
